// File: rtl/mem_resp_if.sv
// Request/response signals of the strobe/ready processor bus.
// The shared data bus stays a plain inout port on the responder.
interface mem_resp_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic              strb;
   logic              rdy;
   logic              proto_err;

   modport master (
      output addr,
      output rw,
      output strb,
      input  rdy,
      input  proto_err
   );

   modport slave (
      input  addr,
      input  rw,
      input  strb,
      output rdy,
      output proto_err
   );
endinterface

// File: rtl/mem_resp.sv
// Memory bus responder: answers an active-low strobe with a one-cycle
// active-low ready after WAIT_CYCLES edges. Writes go to an internal word
// array; reads are driven onto the shared tri-state data bus in ACK and HOLD.
module mem_resp #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_resp_if.slave         bus,
   inout  wire  [DATA_W-1:0] data
);

   localparam int IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StAck,
      StHold
   } state_e;

   state_e              r_state;
   logic [CntW-1:0]     r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rw;
   logic                r_rdy;
   logic                r_perr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_oe;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   state_e              w_state_nxt;
   logic [CntW-1:0]     w_cnt_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_rw_nxt;
   logic                w_rdy_nxt;
   logic                w_perr_nxt;
   logic [DATA_W-1:0]   w_rdata_nxt;
   logic                w_oe_nxt;
   logic                w_mem_we;
   logic                w_in_range;
   logic [IdxW-1:0]     w_idx;

   assign w_in_range = (32'(r_addr) < 32'(DEPTH));
   assign w_idx      = r_addr[IdxW-1:0];

   // Next-state, handshake and bus-driver control for the transfer FSM
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_rw_nxt    = r_rw;
      w_rdy_nxt   = 1'b1;
      w_perr_nxt  = r_perr;
      w_rdata_nxt = r_rdata;
      w_oe_nxt    = r_oe;
      w_mem_we    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!bus.strb) begin
               w_addr_nxt  = bus.addr;
               w_rw_nxt    = bus.rw;
               w_cnt_nxt   = CntLoad;
               w_state_nxt = StBusy;
            end
         end
         StBusy: begin
            if (!bus.strb) begin
               w_perr_nxt = 1'b1;
            end
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CntW'(1);
            end else begin
               w_state_nxt = StAck;
               w_rdy_nxt   = 1'b0;
               if (r_rw) begin
                  // Out-of-range reads return zero rather than aliasing
                  w_rdata_nxt = w_in_range ? r_mem[w_idx] : '0;
                  w_oe_nxt    = 1'b1;
               end else begin
                  w_mem_we = w_in_range;
               end
            end
         end
         StAck: begin
            if (!bus.strb) begin
               w_perr_nxt = 1'b1;
            end
            w_state_nxt = r_rw ? StHold : StIdle;
         end
         StHold: begin
            // Driver releases on the edge that leaves HOLD, even back-to-back
            w_oe_nxt = 1'b0;
            if (!bus.strb) begin
               w_addr_nxt  = bus.addr;
               w_rw_nxt    = bus.rw;
               w_cnt_nxt   = CntLoad;
               w_state_nxt = StBusy;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Control and output registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_rw    <= 1'b0;
         r_rdy   <= 1'b1;
         r_perr  <= 1'b0;
         r_rdata <= '0;
         r_oe    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_addr  <= w_addr_nxt;
         r_rw    <= w_rw_nxt;
         r_rdy   <= w_rdy_nxt;
         r_perr  <= w_perr_nxt;
         r_rdata <= w_rdata_nxt;
         r_oe    <= w_oe_nxt;
      end
   end

   // Word array; deliberately not reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= data;
      end
   end

   assign data          = r_oe ? r_rdata : {DATA_W{1'bz}};
   assign bus.rdy       = r_rdy;
   assign bus.proto_err = r_perr;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: two responders (WAIT_CYCLES 1 and 3) share one
// initiator; a transfer-level model predicts rdy, proto_err, bus drive and
// read data on every cycle.
module tb_mem_resp;

   localparam int Depth = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tb_strb = 1'b1;
   logic        tb_rw = 1'b0;
   logic        tb_oe = 1'b0;
   logic [7:0]  tb_addr = '0;
   logic [15:0] tb_wdata = '0;

   int n_checks = 0;
   int n_fail = 0;

   wire [15:0] data1;
   wire [15:0] data3;

   mem_resp_if #(.ADDR_W(8)) bus1 ();
   mem_resp_if #(.ADDR_W(8)) bus3 ();

   assign bus1.addr = tb_addr;
   assign bus1.rw   = tb_rw;
   assign bus1.strb = tb_strb;
   assign bus3.addr = tb_addr;
   assign bus3.rw   = tb_rw;
   assign bus3.strb = tb_strb;
   assign data1 = tb_oe ? tb_wdata : 16'hzzzz;
   assign data3 = tb_oe ? tb_wdata : 16'hzzzz;

   mem_resp #(.ADDR_W(8), .DATA_W(16), .DEPTH(Depth), .WAIT_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1),
      .data  (data1)
   );

   mem_resp #(.ADDR_W(8), .DATA_W(16), .DEPTH(Depth), .WAIT_CYCLES(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3),
      .data  (data3)
   );

   always #5 clk = ~clk;

   function automatic int wc(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic void check(input string name, input logic [31:0] got,
                                 input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Transfer-level model: one transfer per responder, ready at capture+W
   logic [15:0] mem_m [2][Depth];
   bit          val_m [2][Depth];
   bit          act [2];
   int          ack_at [2];
   int          free_at [2];
   bit          m_rw [2];
   int          m_addr [2];
   logic [15:0] m_rd [2];
   bit          m_rv [2];
   bit          m_perr [2];
   int          edge_n = 0;

   always @(posedge clk) begin
      logic [15:0] dsamp [2];
      logic        exp_rdy;
      logic        exp_oe;
      logic        robs;
      logic        pobs;
      logic        oobs;
      logic [15:0] dobs;
      dsamp[0] = data1;
      dsamp[1] = data3;
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            act[i]    = 1'b0;
            free_at[i] = 0;
            m_perr[i] = 1'b0;
         end else begin
            if (act[i] && edge_n == ack_at[i]) begin
               if (m_rw[i]) begin
                  if (m_addr[i] < Depth) begin
                     m_rd[i] = mem_m[i][m_addr[i]];
                     m_rv[i] = val_m[i][m_addr[i]];
                  end else begin
                     m_rd[i] = 16'h0000;
                     m_rv[i] = 1'b1;
                  end
               end else if (m_addr[i] < Depth) begin
                  mem_m[i][m_addr[i]] = dsamp[i];
                  val_m[i][m_addr[i]] = 1'b1;
               end
            end
            if (!tb_strb) begin
               if (edge_n >= free_at[i]) begin
                  act[i]     = 1'b1;
                  m_rw[i]    = tb_rw;
                  m_addr[i]  = int'(tb_addr);
                  ack_at[i]  = edge_n + wc(i);
                  free_at[i] = edge_n + wc(i) + 2;
               end else begin
                  m_perr[i] = 1'b1;
               end
            end
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_rdy = !(rst_n && act[i] && edge_n == ack_at[i]);
         exp_oe  = rst_n && act[i] && m_rw[i] &&
                   (edge_n == ack_at[i] || edge_n == ack_at[i] + 1);
         robs = (i == 0) ? bus1.rdy : bus3.rdy;
         pobs = (i == 0) ? bus1.proto_err : bus3.proto_err;
         oobs = (i == 0) ? dut1.r_oe : dut3.r_oe;
         dobs = (i == 0) ? data1 : data3;
         check($sformatf("rdy_w%0d@%0d", wc(i), edge_n), 32'(robs), 32'(exp_rdy));
         check($sformatf("proto_err_w%0d@%0d", wc(i), edge_n), 32'(pobs), 32'(m_perr[i]));
         check($sformatf("drive_w%0d@%0d", wc(i), edge_n), 32'(oobs), 32'(exp_oe));
         if (exp_oe && m_rv[i]) begin
            check($sformatf("rdata_w%0d@%0d", wc(i), edge_n), 32'(dobs), 32'(m_rd[i]));
         end
      end
   end

   // One transfer on both responders; optional extra strobe one cycle later
   task automatic xfer(input bit rw, input logic [7:0] a, input logic [15:0] wd,
                       input bit extra, output logic [15:0] rd1,
                       output logic [15:0] rd3, output int lat1, output int lat3);
      bit d1;
      bit d3;
      d1 = 1'b0;
      d3 = 1'b0;
      lat1 = -1;
      lat3 = -1;
      rd1 = '0;
      rd3 = '0;
      @(negedge clk);
      tb_strb = 1'b0;
      tb_rw   = rw;
      tb_addr = a;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            tb_strb = extra ? 1'b0 : 1'b1;
            if (!rw) begin
               tb_wdata = wd;
               tb_oe    = 1'b1;
            end
         end
         if (k == 2) tb_strb = 1'b1;
         if (!d1 && !bus1.rdy) begin
            d1 = 1'b1;
            lat1 = k;
            rd1 = data1;
         end
         if (!d3 && !bus3.rdy) begin
            d3 = 1'b1;
            lat3 = k;
            rd3 = data3;
         end
         if (d1 && d3 && k >= 2) break;
      end
      tb_oe   = 1'b0;
      tb_strb = 1'b1;
      if (!(d1 && d3)) begin
         n_checks++;
         n_fail++;
         $display("FAIL xfer_timeout addr %0h: rdy seen w1=%0d w3=%0d required both 1",
                  a, d1, d3);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r1, r3;
      int l1, l3;
      bit seen;

      repeat (3) @(negedge clk);
      check("reset_rdy_w1", 32'(bus1.rdy), 32'd1);
      check("reset_perr_w3", 32'(bus3.proto_err), 32'd0);
      rst_n = 1'b1;

      // Write data=addr to 0..9, then read back
      for (int a = 0; a < 10; a++) begin
         xfer(1'b0, 8'(a), 16'(a), 1'b0, r1, r3, l1, l3);
      end
      for (int a = 0; a < 10; a++) begin
         xfer(1'b1, 8'(a), 16'h0, 1'b0, r1, r3, l1, l3);
         check($sformatf("readback_w1_%0d", a), 32'(r1), 32'(a));
         check($sformatf("readback_w3_%0d", a), 32'(r3), 32'(a));
      end
      check("latency_w1", 32'(l1), 32'd2);
      check("latency_w3", 32'(l3), 32'd4);

      // Out-of-range write is dropped, read returns zero
      xfer(1'b0, 8'h14, 16'hBEEF, 1'b0, r1, r3, l1, l3);
      xfer(1'b1, 8'h04, 16'h0, 1'b0, r1, r3, l1, l3);
      check("oor_mem4_w1", 32'(r1), 32'h0004);
      check("oor_mem4_w3", 32'(r3), 32'h0004);
      xfer(1'b1, 8'h14, 16'h0, 1'b0, r1, r3, l1, l3);
      check("oor_read_w1", 32'(r1), 32'h0000);
      check("oor_read_w3", 32'(r3), 32'h0000);

      // Back-to-back reads; second strobe lands in HOLD on the slow responder
      xfer(1'b1, 8'h03, 16'h0, 1'b0, r1, r3, l1, l3);
      check("b2b_first_w3", 32'(r3), 32'h0003);
      xfer(1'b1, 8'h05, 16'h0, 1'b0, r1, r3, l1, l3);
      check("b2b_second_w3", 32'(r3), 32'h0005);
      check("b2b_second_w1", 32'(r1), 32'h0005);
      check("no_perr_w1", 32'(bus1.proto_err), 32'd0);

      // Randomized traffic, including out-of-range and idle gaps
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 16'($urandom),
              1'b0, r1, r3, l1, l3);
      end

      // Protocol error: second strobe during BUSY of a write
      xfer(1'b0, 8'h02, 16'h1234, 1'b1, r1, r3, l1, l3);
      check("perr_set_w1", 32'(bus1.proto_err), 32'd1);
      check("perr_set_w3", 32'(bus3.proto_err), 32'd1);
      xfer(1'b1, 8'h02, 16'h0, 1'b0, r1, r3, l1, l3);
      check("perr_mem2_w1", 32'(r1), 32'h1234);
      check("perr_mem2_w3", 32'(r3), 32'h1234);
      check("perr_sticky_w3", 32'(bus3.proto_err), 32'd1);

      // Reset during read ACK on the slow responder: outputs drop at once
      xfer(1'b0, 8'h07, 16'h0007, 1'b0, r1, r3, l1, l3);
      @(negedge clk);
      tb_strb = 1'b0;
      tb_rw   = 1'b1;
      tb_addr = 8'h07;
      @(negedge clk);
      tb_strb = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!bus3.rdy) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("ack_reached_w3", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_rdy_w3", 32'(bus3.rdy), 32'd1);
      check("async_rst_drive_w3", 32'(dut3.r_oe), 32'd0);
      check("async_rst_perr_w3", 32'(bus3.proto_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-write before the commit edge: addr 7 keeps 0007
      @(negedge clk);
      tb_strb = 1'b0;
      tb_rw   = 1'b0;
      tb_addr = 8'h07;
      @(negedge clk);
      tb_strb  = 1'b1;
      tb_wdata = 16'hAAAA;
      tb_oe    = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_write_rdy_w1", 32'(bus1.rdy), 32'd1);
      check("rst_write_drive_w1", 32'(dut1.r_oe), 32'd0);
      check("rst_write_drive_w3", 32'(dut3.r_oe), 32'd0);
      @(negedge clk);
      tb_oe = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      xfer(1'b1, 8'h07, 16'h0, 1'b0, r1, r3, l1, l3);
      check("rst_write_mem7_w1", 32'(r1), 32'h0007);
      check("rst_write_mem7_w3", 32'(r3), 32'h0007);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_resp.md
# mem_resp

Bus responder (memory slave) for the team's strobe/ready processor bus. It answers the initiator's active-low strobe with a single-cycle active-low ready after a programmable number of wait states. It stores write data in an internal word array and drives read data onto the shared tri-state data bus. It sits opposite the processor model in bus-level testbenches and serves as the reference memory target for synthesizable bus experiments.

## Interface
- ADDR_W, 8, address width.
- DATA_W, 16, data word width.
- DEPTH, 16, number of implemented words at addresses 0..DEPTH-1; DEPTH ≤ 2^ADDR_W.
- WAIT_CYCLES, 1, clock edges from strobe capture to ready assertion; legal range ≥1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- addr  in  ADDR_W  word address; sampled when the strobe is captured.
- data  inout  DATA_W  shared bus. The initiator drives it for writes; this block drives it only during read ACK and HOLD, and leaves it high-Z otherwise.
- rw  in  1  1 = read, 0 = write; sampled with addr.
- strb  in  1  active-low request strobe, one cycle wide.
- rdy  out  1  active-low completion, registered.
- proto_err  out  1  sticky flag: strobe seen while the block is busy. Cleared only by reset.

## Operation
- States: IDLE, BUSY, ACK, HOLD.
- IDLE or HOLD, strb==0 at an edge:
  - capture addr and rw;
  - load the wait counter with WAIT_CYCLES-1;
  - go to BUSY.
- HOLD with strb==1 goes to IDLE. HOLD must accept a new strobe so back-to-back transfers are not lost.
- BUSY, counter nonzero: decrement. BUSY, counter zero: go to ACK and register rdy=0. On that same edge:
  - write: sample data and commit it to mem[addr];
  - read: register mem[addr] into the output register and enable the bus driver.
- ACK always lasts one cycle; rdy returns to 1 on the next edge. After ACK, a write goes to IDLE and a read goes to HOLD.
- HOLD lasts one cycle and keeps the read data driven. The bus driver releases on the edge that leaves HOLD.
- Out-of-range address (addr ≥ DEPTH):
  - write is discarded with no array change;
  - read returns all zeros;
  - the ready handshake still completes normally.
- strb==0 sampled in BUSY or ACK: ignored, the current transfer is unaffected, and proto_err is set to 1.
- Memory array is not reset; contents are retained across rst_n.

## Timing
- Reset values: rdy=1, data=high-Z, proto_err=0, state IDLE, counter 0.
- Reset mid-transfer: asynchronous return to reset values. A write whose commit edge has not yet occurred is not stored.
- Strobe captured at edge E0. rdy goes low after edge E0+WAIT_CYCLES. The initiator sees rdy==0 at edge E0+WAIT_CYCLES+1, and rdy returns high after that same edge.
- Write data is sampled at E0+WAIT_CYCLES; the initiator must hold data valid through that edge. Since WAIT_CYCLES ≥ 1, data first presented after E0 is captured.
- Read data is stable from just after E0+WAIT_CYCLES through E0+WAIT_CYCLES+2, so the initiator can sample it in the same timestep it observes rdy==0.
- Minimum transfer period: WAIT_CYCLES+2 edges. A new strobe may be sampled at E0+WAIT_CYCLES+2, which is the HOLD or IDLE edge.
- The data bus is never driven by this block in the same cycle as a write. This block drives only in ACK and HOLD of a read, and the initiator has released the bus by then.

## Test plan
- Write/readback, WAIT_CYCLES=1: write data=addr to addresses 0..9, then read 0..9. Every read returns its address, each rdy pulse is exactly 1 cycle, and proto_err stays 0.
- Latency, WAIT_CYCLES=3: strobe captured at edge E0. rdy is low only between edges E0+3 and E0+4, and data stays high-Z outside ACK/HOLD.
- Out of range, DEPTH=16:
  - write 16'hBEEF to addr 8'h14: rdy pulses and mem[4] is unchanged;
  - read of addr 8'h14 returns 16'h0000.
- Back-to-back: read addr 3 immediately followed by a read of addr 5, with the strobe sampled in HOLD. Both complete, returning 0003 and 0005, and neither strobe is lost.
- Protocol error: second strobe asserted during BUSY of a write to addr 2 (data 16'h1234). proto_err goes to 1 and stays; only one rdy pulse occurs; mem[2] is 16'h1234.
- Reset mid-write:
  - rst_n is pulled low in BUSY, before the commit edge, while writing 16'hAAAA to addr 7, which previously held 0007;
  - rdy goes to 1 and data goes high-Z immediately;
  - after reset, a read of addr 7 returns 0007.
